spm_seq: RTL and testbench
==========================

// Module: spm_seq
// PURPOSE
//  Parametrised, handshaked serial-parallel multiplier (SPM) built on the carry-save
//  adder cell chain. Multiplicand is held in parallel, multiplier is consumed
//  LSB first, product leaves serially LSB first and is assembled into a parallel register.
//  Adds start/busy/done sequencing, signed/unsigned mode and generic width to the 8-bit SPM.
//  Sits between operand registers and the result consumer in the arithmetic datapath.
// PARAMETERS
//  WIDTH   8  operand width in bits; WIDTH >= 2; product is 2*WIDTH bits
//  SIGNED  1  1: two's-complement operands and product; 0: unsigned
// PORTS
//  clk           in   1        clock; all state changes on rising edge
//  rst           in   1        asynchronous reset, active-high
//  clr           in   1        synchronous clear; same effect as rst, but on the clock edge
//  start         in   1        request; sampled only while ready=1
//  multiplicand  in   WIDTH    operand A; captured on the accepting edge
//  multiplier    in   WIDTH    operand B; captured on the accepting edge
//  ready         out  1        1 in IDLE: start is accepted on this edge
//  busy          out  1        1 in RUN
//  done          out  1        one-cycle pulse; product valid from this cycle
//  prod_bit      out  1        serial product bit, LSB first
//  prod_bit_vld  out  1        prod_bit qualifier; high for exactly 2*WIDTH cycles per op
//  product       out  2*WIDTH  parallel product; held until the next accepted start
// BEHAVIOUR
//  Reset (rst or clr): state=IDLE, ready=1, busy=0, done=0, prod_bit=0, prod_bit_vld=0,
//   product=0, bit counter=0, CSA sum/carry chain=0. rst wins over clr; both win over start.
//  FSM states IDLE -> RUN -> DONE -> IDLE.
//   IDLE: start=1 latches A, B into the operand registers, clears the CSA chain, counter=0,
//    and goes to RUN. start=0 stays in IDLE.
//   RUN: each cycle shifts one multiplier bit into the array and emits one product bit;
//    counter counts 0..2*WIDTH-1. Cycles WIDTH..2*WIDTH-1 feed the multiplier sign bit
//    (SIGNED=1) or 0 (SIGNED=0). Leaves RUN after the bit with counter=2*WIDTH-1.
//   DONE: one cycle only; done=1, and product holds all 2*WIDTH bits. Next edge -> IDLE.
//  Timing: start accepted at edge k -> busy=1 for cycles k+1..k+2*WIDTH; prod_bit_vld
//   follows busy exactly; product bit j appears in cycle k+1+j; done=1 in cycle k+2*WIDTH+1;
//   ready=1 again from cycle k+2*WIDTH+2. Latency start-edge -> done = 2*WIDTH+1 cycles.
//  start in RUN or DONE is ignored; operands are not re-sampled and no op is queued.
//  Operand inputs may change freely after the accepting edge.
//  Arithmetic: product = A*B mod 2^(2*WIDTH). SIGNED=1 handles the multiplicand MSB
//   column with a two's-complement cell (negated partial product); SIGNED=0 uses a plain
//   CSA cell in that column. No overflow is possible at 2*WIDTH bits.
//  product register is shifted in from prod_bit during RUN; it is not reset by start, only
//   by rst/clr, so its value is meaningless while busy=1 until done.
//  rst/clr mid-RUN: operation aborted, no done pulse, outputs return to reset values.
//  Corner operands: A=0 or B=0 -> product=0; SIGNED=1 with A=B=-2^(WIDTH-1) -> 2^(2*WIDTH-2).
// TESTING
//  T1 WIDTH=8 SIGNED=0: A=255, B=255, start 1 cycle -> done 17 cycles after start edge,
//     product=16'hFE01; prod_bit stream LSB first = 1,0,0,0,0,0,0,0,0,1,1,1,1,1,1,1.
//  T2 WIDTH=8 SIGNED=1: A=-128 (8'h80), B=-128 -> product=16'h4000; A=-1, B=1 -> 16'hFFFF;
//     A=7, B=-3 -> 16'hFFEB.
//  T3 start held high through RUN and DONE with new operands -> exactly one done, product
//     of the first operands; second op starts only on the first edge with ready=1.
//  T4 rst asserted asynchronously mid-clock in cycle 5 of RUN -> all outputs zero immediately,
//     no done; clr at cycle 5 -> same at next edge; new start after either gives correct result.
//  T5 WIDTH=16 SIGNED=1: 1000 random operand pairs back-to-back -> product equals reference
//     A*B for all, done spacing = 34 cycles, prod_bit_vld high exactly 32 cycles per op.
//  T6 A=0 or B=0 at both widths and modes -> product=0, done timing unchanged.

Source files
------------

// File: rtl/spm_seq.sv
// rtl/spm_seq.sv - handshaked serial-parallel multiplier on a carry-save adder cell chain
// Multiplicand held in parallel, multiplier consumed LSB first, product emitted LSB first.
module spm_seq #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic               prod_bit,
    output logic               prod_bit_vld,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(2*WIDTH);
    localparam logic [CW-1:0] LAST = CW'(2*WIDTH-1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t           state, state_d;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:1] sum_q;
    logic [WIDTH-1:0] carry_q;
    logic [WIDTH-1:0] sum_d, carry_d, sum_in, pp;
    logic             corr, x_bit, fill;

    // Signed mode negates the MSB-column partial product; the constant that this
    // introduces over 2*WIDTH cycles reduces to one 1 injected into that column at bit 0.
    always_comb begin
        corr   = SIGNED && (cnt == '0);
        sum_in = {corr, sum_q};
        x_bit  = b_sh[0];
        fill   = SIGNED & b_sh[WIDTH-1];
        pp     = '0;
        sum_d  = '0;
        carry_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pp[i]      = (a_reg[i] & x_bit) ^ (SIGNED && (i == WIDTH-1));
            sum_d[i]   = pp[i] ^ sum_in[i] ^ carry_q[i];
            carry_d[i] = (pp[i] & sum_in[i]) | (pp[i] & carry_q[i]) | (sum_in[i] & carry_q[i]);
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (cnt == LAST) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            a_reg   <= '0;
            b_sh    <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            product <= '0;
        end else if (clr) begin
            cnt     <= '0;
            a_reg   <= '0;
            b_sh    <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            product <= '0;
        end else if (state == ST_IDLE) begin
            if (start) begin
                a_reg   <= multiplicand;
                b_sh    <= multiplier;
                sum_q   <= '0;
                carry_q <= '0;
                cnt     <= '0;
            end
        end else if (state == ST_RUN) begin
            // Once the real multiplier bits are used up, the sign (or zero) keeps feeding.
            b_sh    <= {fill, b_sh[WIDTH-1:1]};
            sum_q   <= sum_d[WIDTH-1:1];
            carry_q <= carry_d;
            cnt     <= cnt + 1'b1;
            product <= {prod_bit, product[2*WIDTH-1:1]};
        end
    end

    assign ready        = (state == ST_IDLE);
    assign busy         = (state == ST_RUN);
    assign done         = (state == ST_DONE);
    assign prod_bit_vld = busy;
    assign prod_bit     = busy & sum_d[0];

endmodule

// File: tb/tb_spm_seq.sv
// tb/tb_spm_seq.sv - bench for spm_seq at 8/16 bits, signed and unsigned, against a cycle model
module tb_spm_seq;

    logic        clk = 1'b0;
    logic        rst, clr, start;
    logic [15:0] mcand, mplier;
    logic [3:0]  rdy, bsy, dn, pb, pbv;
    logic [15:0] p0, p1;
    logic [31:0] p2, p3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spm_seq #(.WIDTH(8), .SIGNED(1'b0)) u0 (
        .clk(clk), .rst(rst), .clr(clr), .start(start),
        .multiplicand(mcand[7:0]), .multiplier(mplier[7:0]),
        .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .prod_bit(pb[0]),
        .prod_bit_vld(pbv[0]), .product(p0));

    spm_seq #(.WIDTH(8), .SIGNED(1'b1)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .start(start),
        .multiplicand(mcand[7:0]), .multiplier(mplier[7:0]),
        .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .prod_bit(pb[1]),
        .prod_bit_vld(pbv[1]), .product(p1));

    spm_seq #(.WIDTH(16), .SIGNED(1'b1)) u2 (
        .clk(clk), .rst(rst), .clr(clr), .start(start),
        .multiplicand(mcand), .multiplier(mplier),
        .ready(rdy[2]), .busy(bsy[2]), .done(dn[2]), .prod_bit(pb[2]),
        .prod_bit_vld(pbv[2]), .product(p2));

    spm_seq #(.WIDTH(16), .SIGNED(1'b0)) u3 (
        .clk(clk), .rst(rst), .clr(clr), .start(start),
        .multiplicand(mcand), .multiplier(mplier),
        .ready(rdy[3]), .busy(bsy[3]), .done(dn[3]), .prod_bit(pb[3]),
        .prod_bit_vld(pbv[3]), .product(p3));

    function automatic int wid(input int i);
        return (i < 2) ? 8 : 16;
    endfunction

    function automatic bit sgn(input int i);
        return (i == 1) || (i == 2);
    endfunction

    function automatic logic [31:0] prod_of(input int i);
        case (i)
            0:       return {16'h0, p0};
            1:       return {16'h0, p1};
            2:       return p2;
            default: return p3;
        endcase
    endfunction

    // Reference: interpret operands at width w (signed or not), multiply, keep 2w bits.
    function automatic logic [31:0] ref_mul(input int w, input bit s,
                                            input logic [15:0] a, input logic [15:0] b);
        longint m, aa, bb, pr;
        m  = (longint'(1) << w) - 1;
        aa = longint'(a) & m;
        bb = longint'(b) & m;
        if (s && ((aa >> (w-1)) & 1) == 1) aa = aa - (longint'(1) << w);
        if (s && ((bb >> (w-1)) & 1) == 1) bb = bb - (longint'(1) << w);
        pr = (aa * bb) & ((longint'(1) << (2*w)) - 1);
        return pr[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: cycles elapsed since the accepting edge (0 = idle), expected product, held product.
    int          el[4]   = '{0, 0, 0, 0};
    logic [31:0] exp_p[4] = '{default: 32'h0};
    logic [31:0] held[4]  = '{default: 32'h0};

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 4; i++) begin
            if (rst || clr) begin
                el[i]   <= 0;
                held[i] <= 32'h0;
            end else if (el[i] == 2*wid(i) + 1) begin
                el[i] <= 0;
            end else if (el[i] > 0) begin
                el[i] <= el[i] + 1;
                if (el[i] == 2*wid(i)) held[i] <= exp_p[i];
            end else if (start) begin
                el[i]    <= 1;
                exp_p[i] <= ref_mul(wid(i), sgn(i), mcand, mplier);
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int i = 0; i < 4; i++) begin
                int w;
                bit run_e;
                w     = wid(i);
                run_e = (el[i] >= 1) && (el[i] <= 2*w);
                chk($sformatf("ready%0d", i), 32'(rdy[i]), 32'(el[i] == 0));
                chk($sformatf("busy%0d", i), 32'(bsy[i]), 32'(run_e));
                chk($sformatf("done%0d", i), 32'(dn[i]), 32'(el[i] == 2*w + 1));
                chk($sformatf("vld%0d", i), 32'(pbv[i]), 32'(run_e));
                chk($sformatf("prod_bit%0d", i), 32'(pb[i]),
                    run_e ? 32'(exp_p[i][el[i]-1]) : 32'h0);
                if (!run_e) chk($sformatf("product%0d", i), prod_of(i), held[i]);
            end
        end
    end

    int          lat0;
    logic [15:0] stream0;

    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b);
        bit got;
        start_op(a, b);
        lat0 = 0;
        got = 1'b0;
        stream0 = 16'h0;
        for (int c = 1; c <= 40; c++) begin
            if (pbv[0]) stream0 = {pb[0], stream0[15:1]};
            if (dn[0] && lat0 == 0) lat0 = c;
            if (dn[2]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) chk("run_op_timeout", 32'h0, 32'h1);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nd, n_done, last, vcnt, cyc;
        rst = 1'b1; clr = 1'b0; start = 1'b0; mcand = 16'h0; mplier = 16'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(rdy), 32'hF);
        chk("rst_busy", 32'(bsy), 32'h0);
        chk("rst_done", 32'(dn), 32'h0);
        chk("rst_vld", 32'(pbv), 32'h0);
        chk("rst_prod0", 32'(p0), 32'h0);
        chk("rst_prod2", p2, 32'h0);

        // T1
        run_op(16'h00FF, 16'h00FF);
        chk("t1_prod", 32'(p0), 32'hFE01);
        chk("t1_stream", 32'(stream0), 32'hFE01);
        chk("t1_latency", 32'(lat0), 32'd17);

        // T2
        run_op(16'hFF80, 16'hFF80);
        chk("t2_min8", 32'(p1), 32'h4000);
        run_op(16'h8000, 16'h8000);
        chk("t2_min16", p2, 32'h4000_0000);
        run_op(16'hFFFF, 16'h0001);
        chk("t2_m1", 32'(p1), 32'hFFFF);
        chk("t2_m1_16", p2, 32'hFFFF_FFFF);
        run_op(16'h0007, 16'hFFFD);
        chk("t2_7xm3", 32'(p1), 32'hFFEB);
        chk("t2_7x253u", 32'(p0), 32'h06EB);

        // T3: start held high with operands changing after acceptance
        start = 1'b1; mcand = 16'd5; mplier = 16'd6;
        @(negedge clk);
        mcand = 16'd9; mplier = 16'd9; nd = 0;
        for (int c = 1; c <= 34; c++) begin
            if (dn[0]) nd++;
            if (c == 17) begin
                chk("t3_done17", 32'(dn[0]), 32'h1);
                chk("t3_first", 32'(p0), 32'd30);
            end
            if (c == 33) chk("t3_first16", p2, 32'd30);
            if (c == 34) start = 1'b0;
            @(negedge clk);
        end
        chk("t3_one_done", 32'(nd), 32'd1);
        chk("t3_second_done", 32'(dn[0]), 32'h1);
        chk("t3_second", 32'(p0), 32'd81);
        repeat (20) @(negedge clk);

        // T4: async reset mid-run, then clr mid-run
        start_op(16'd100, 16'd3);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t4_rst_busy", 32'(bsy), 32'h0);
        chk("t4_rst_vld", 32'(pbv), 32'h0);
        chk("t4_rst_pb", 32'(pb), 32'h0);
        chk("t4_rst_ready", 32'(rdy), 32'hF);
        chk("t4_rst_prod", p2, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(16'd100, 16'd3);
        chk("t4_after_rst", 32'(p0), 32'd300);
        start_op(16'd100, 16'd3);
        repeat (4) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("t4_clr_busy", 32'(bsy), 32'h0);
        chk("t4_clr_prod", 32'(p0), 32'h0);
        chk("t4_clr_done", 32'(dn), 32'h0);
        run_op(16'hFFFF, 16'h0001);
        chk("t4_after_clr", 32'(p1), 32'hFFFF);

        // T6
        run_op(16'h0000, 16'd1234);
        chk("t6_a0_8", 32'(p0), 32'h0);
        chk("t6_a0_16", p2, 32'h0);
        chk("t6_latency", 32'(lat0), 32'd17);
        run_op(16'hFFFB, 16'h0000);
        chk("t6_b0_8s", 32'(p1), 32'h0);
        chk("t6_b0_16u", p3, 32'h0);

        // T5: 1000 back-to-back random ops, measured on the 16-bit signed instance
        start = 1'b1; n_done = 0; last = -1; vcnt = 0; cyc = 0;
        while (n_done < 1000 && cyc < 40000) begin
            mcand  = 16'($urandom());
            mplier = 16'($urandom());
            @(negedge clk);
            cyc++;
            if (pbv[2]) vcnt++;
            if (dn[2]) begin
                if (last >= 0) chk("t5_spacing", 32'(cyc - last), 32'd34);
                chk("t5_vld_count", 32'(vcnt), 32'd32);
                vcnt = 0;
                last = cyc;
                n_done++;
            end
        end
        start = 1'b0;
        if (n_done < 1000) chk("t5_timeout", 32'(n_done), 32'd1000);
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
